// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the register writeback queue.
package wb_pkg;
  localparam int WB_XLEN   = 32;
  localparam int WB_REG_AW = 5;

  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the live entries of the writeback queue.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [REG_AW-1:0]          q_reg,
  output logic                       q_hit,
  output logic [XLEN-1:0]            q_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (q_reg != '0) && (entries[idx].rd == q_reg)) begin
        q_hit  = 1'b1;
        q_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Two-producer in-order writeback FIFO draining one register-file write per cycle,
// with two forwarding query ports over the pending entries.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  output logic              reg_write,
  output logic [REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]   write_data,
  input  logic [REG_AW-1:0] q_reg1,
  output logic              q_hit1,
  output logic [XLEN-1:0]   q_data1,
  input  logic [REG_AW-1:0] q_reg2,
  output logic              q_hit2,
  output logic [XLEN-1:0]   q_data2,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t     entries_q [DEPTH];
  wb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] b_slot;
  logic [CW-1:0] count_q, count_d;
  logic          a_push, b_push, pop;
  wb_entry_t     head;

  // Ready looks only at the registered count; the same-cycle pop earns no credit.
  assign a_ready = (count_q < DEPTH_C);
  assign b_ready = ((count_q + CW'(a_valid)) < DEPTH_C);

  // Writes to x0 finish their handshake but never occupy a slot.
  assign a_push = a_valid && a_ready && (a_rd != '0);
  assign b_push = b_valid && b_ready && (b_rd != '0);
  assign pop    = (count_q != '0);

  always_comb begin
    entries_d = entries_q;
    b_slot    = wr_ptr_q + PW'(a_push);
    if (a_push) entries_d[wr_ptr_q] = '{rd: a_rd, data: a_data};
    if (b_push) entries_d[b_slot]   = '{rd: b_rd, data: b_data};
    wr_ptr_d = wr_ptr_q + PW'(a_push) + PW'(b_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(a_push) + CW'(b_push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_q[i].data <= entries_d[i].data;
      entries_q[i].rd   <= rst ? '0 : entries_d[i].rd;
    end
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // The head drains every cycle it exists; the register file never stalls.
  assign head       = entries_q[rd_ptr_q];
  assign reg_write  = pop;
  assign write_reg  = pop ? head.rd   : '0;
  assign write_data = pop ? head.data : '0;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
    .entries (entries_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .q_reg   (q_reg1),
    .q_hit   (q_hit1),
    .q_data  (q_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
    .entries (entries_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .q_reg   (q_reg2),
    .q_hit   (q_hit2),
    .q_data  (q_data2)
  );
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue.
module tb_reg_writeback_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, write_reg, q_reg1, q_reg2;
  logic [31:0] a_data, b_data, write_data, q_data1, q_data2;
  logic        reg_write, q_hit1, q_hit2, full, empty;

  int errors = 0;
  int checks = 0;

  logic [4:0]  sb_rd[$];
  logic [31:0] sb_data[$];

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(4), .XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .q_reg1(q_reg1), .q_hit1(q_hit1), .q_data1(q_data1),
    .q_reg2(q_reg2), .q_hit2(q_hit2), .q_data2(q_data2),
    .full(full), .empty(empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  task automatic test_reset();
    idle();
    q_reg1 = 5'd5; q_reg2 = 5'd5;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", reg_write); end
    checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL rst_wreg: got %0d want 0", write_reg); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", write_data); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %0b want 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %0b want 1", b_ready); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b want 1", empty); end
    checks++; if (q_hit1 !== 1'b0 || q_data1 !== 32'd0) begin errors++; $display("FAIL rst_q1: got hit=%0b data=%h want 0/0", q_hit1, q_data1); end
    checks++; if (q_hit2 !== 1'b0 || q_data2 !== 32'd0) begin errors++; $display("FAIL rst_q2: got hit=%0b data=%h want 0/0", q_hit2, q_data2); end
  endtask

  task automatic test_single_write();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL sw_a_ready: got %0b want 1", a_ready); end
    tick();
    idle();
    #1;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL sw_we: got %0b want 1", reg_write); end
    checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL sw_wreg: got %0d want 5", write_reg); end
    checks++; if (write_data !== 32'h1234) begin errors++; $display("FAIL sw_wdata: got %h want 00001234", write_data); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL sw_empty_busy: got %0b want 0", empty); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL sw_we_after: got %0b want 0", reg_write); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sw_empty_after: got %0b want 1", empty); end
  endtask

  task automatic test_dual_push();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hA;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hB;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL dp_ready: got a=%0b b=%0b want 1/1", a_ready, b_ready); end
    tick();
    idle();
    q_reg1 = 5'd3; q_reg2 = 5'd4;
    #1;
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'hA) begin errors++; $display("FAIL dp_first: got we=%0b reg=%0d data=%h want 1/3/0000000a", reg_write, write_reg, write_data); end
    checks++; if (q_hit1 !== 1'b1 || q_data1 !== 32'hB) begin errors++; $display("FAIL dp_fwd_young: got hit=%0b data=%h want 1/0000000b", q_hit1, q_data1); end
    checks++; if (q_hit2 !== 1'b0 || q_data2 !== 32'd0) begin errors++; $display("FAIL dp_fwd_miss: got hit=%0b data=%h want 0/0", q_hit2, q_data2); end
    tick();
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'hB) begin errors++; $display("FAIL dp_second: got we=%0b reg=%0d data=%h want 1/3/0000000b", reg_write, write_reg, write_data); end
    checks++; if (q_hit1 !== 1'b1 || q_data1 !== 32'hB) begin errors++; $display("FAIL dp_fwd_head: got hit=%0b data=%h want 1/0000000b", q_hit1, q_data1); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL dp_done: got we=%0b want 0", reg_write); end
    checks++; if (q_hit1 !== 1'b0 || q_data1 !== 32'd0) begin errors++; $display("FAIL dp_fwd_gone: got hit=%0b data=%h want 0/0", q_hit1, q_data1); end
  endtask

  task automatic test_x0_drop();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    q_reg1 = 5'd0;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready: got %0b want 1", a_ready); end
    tick();
    idle();
    #1;
    checks++; if (reg_write !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL x0_dropped: got we=%0b empty=%0b want 0/1", reg_write, empty); end
    checks++; if (q_hit1 !== 1'b0) begin errors++; $display("FAIL x0_fwd: got hit=%0b want 0", q_hit1); end
    // x0 on A alongside a real B request: only B lands.
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h66;
    tick();
    idle();
    #1;
    checks++; if (reg_write !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'h66) begin errors++; $display("FAIL x0_mixed: got we=%0b reg=%0d data=%h want 1/6/00000066", reg_write, write_reg, write_data); end
    tick();
    checks++; if (reg_write !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL x0_mixed_done: got we=%0b empty=%0b want 0/1", reg_write, empty); end
  endtask

  task automatic test_backpressure();
    logic exp_b;
    sb_rd.delete(); sb_data.delete();
    for (int k = 0; k < 10; k++) begin
      a_valid = 1'b1; a_rd = 5'(k + 1);  a_data = 32'hA00 + k;
      b_valid = 1'b1; b_rd = 5'(k + 16); b_data = 32'hB00 + k;
      // Counts run 0, 2, then hold at 3: B loses its slot from the third cycle on.
      exp_b = (k < 2);
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_a_ready[%0d]: got %0b want 1", k, a_ready); end
      checks++; if (b_ready !== exp_b) begin errors++; $display("FAIL bp_b_ready[%0d]: got %0b want %0b", k, b_ready, exp_b); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL bp_full[%0d]: got %0b want 0", k, full); end
      if (sb_rd.size() > 0) begin
        checks++; if (reg_write !== 1'b1 || write_reg !== sb_rd[0] || write_data !== sb_data[0]) begin errors++; $display("FAIL bp_write[%0d]: got we=%0b reg=%0d data=%h want 1/%0d/%h", k, reg_write, write_reg, write_data, sb_rd[0], sb_data[0]); end
        void'(sb_rd.pop_front()); void'(sb_data.pop_front());
      end else begin
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL bp_idle[%0d]: got we=%0b want 0", k, reg_write); end
      end
      sb_rd.push_back(a_rd); sb_data.push_back(a_data);
      if (exp_b) begin sb_rd.push_back(b_rd); sb_data.push_back(b_data); end
      tick();
    end
    idle();
    for (int n = 0; n < 8 && sb_rd.size() > 0; n++) begin
      #1;
      checks++; if (reg_write !== 1'b1 || write_reg !== sb_rd[0] || write_data !== sb_data[0]) begin errors++; $display("FAIL bp_drain[%0d]: got we=%0b reg=%0d data=%h want 1/%0d/%h", n, reg_write, write_reg, write_data, sb_rd[0], sb_data[0]); end
      void'(sb_rd.pop_front()); void'(sb_data.pop_front());
      tick();
    end
    checks++; if (sb_rd.size() != 0) begin errors++; $display("FAIL bp_drain_bound: %0d writes outstanding want 0", sb_rd.size()); end
    #1;
    checks++; if (reg_write !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got we=%0b empty=%0b want 0/1", reg_write, empty); end
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h70;
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h80;
    tick();
    a_rd = 5'd9;  a_data = 32'h90;
    b_rd = 5'd10; b_data = 32'hA0;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rm_b_ready: got %0b want 1", b_ready); end
    tick();
    idle();
    q_reg1 = 5'd9; q_reg2 = 5'd10;
    #1;
    checks++; if (q_hit1 !== 1'b1 || q_data1 !== 32'h90) begin errors++; $display("FAIL rm_fwd_pre: got hit=%0b data=%h want 1/00000090", q_hit1, q_data1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (reg_write !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rm_flushed: got we=%0b empty=%0b want 0/1", reg_write, empty); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got a=%0b b=%0b want 1/1", a_ready, b_ready); end
    checks++; if (q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin errors++; $display("FAIL rm_fwd: got hit1=%0b hit2=%0b want 0/0", q_hit1, q_hit2); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rm_stays_idle: got we=%0b want 0", reg_write); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    q_reg1 = '0; q_reg2 = '0;
    test_reset();
    test_single_write();
    test_dual_push();
    test_x0_drop();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
